// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and bit-level helpers.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

    localparam int         UART_OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A        = 4'd7;
    localparam logic [3:0] SAMPLE_B        = 4'd8;
    localparam logic [3:0] SAMPLE_C        = 4'd9;
    localparam logic [3:0] SCNT_LAST       = 4'd15;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-accumulator tick generator: one-clk tick at TICK_RATE on average from CLK_FREQ.
module uart_baud_tick #(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int TICK_RATE = 115200 * 16
) (
    input  logic clk,
    input  logic I_rst,
    input  logic clear,
    output logic tick
);

    localparam logic [32:0] INC   = 33'(TICK_RATE);
    localparam logic [32:0] LIMIT = 33'(CLK_FREQ);

    logic [31:0] acc_r;
    logic [32:0] sum_s;
    logic        tick_r;

    always_comb begin
        sum_s = {1'b0, acc_r} + INC;
    end

    // Accumulate; on overflow past CLK_FREQ keep the remainder so the long-run rate is exact.
    always_ff @(posedge clk) begin
        if (I_rst || clear) begin
            acc_r  <= 32'd0;
            tick_r <= 1'b0;
        end else if (sum_s >= LIMIT) begin
            acc_r  <= 32'(sum_s - LIMIT);
            tick_r <= 1'b1;
        end else begin
            acc_r  <= sum_s[31:0];
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver with valid/ready delivery and error pulses.
// Define UART_RX_PARITY_EN for 8E1 frames (adds PARITY state); default is 8N1.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       I_rst,
    input  logic       I_rx,
    output logic [7:0] O_data,
    output logic       O_valid,
    input  logic       I_ready,
    output logic       O_frame_err,
    output logic       O_parity_err,
    output logic       O_overrun,
    output logic       O_busy
);

    uart_state_e state_r, state_s;
    logic        rx_meta_r, rx_s;
    logic [3:0]  scnt_r;
    logic [1:0]  samp_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        par_err_r;
    logic        tick_s, acc_clear_s, maj_s, stop_eval_s;
    logic        deliver_s, frame_s, perr_s;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_RATE (BAUD * OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .I_rst (I_rst),
        .clear (acc_clear_s),
        .tick  (tick_s)
    );

    // Two-flop synchronizer, idle-high through reset.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            rx_meta_r <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_r <= I_rx;
            rx_s      <= rx_meta_r;
        end
    end

    // Next-state logic; the third vote is taken live on the scnt==9 tick.
    always_comb begin
        state_s     = state_r;
        acc_clear_s = 1'b0;
        maj_s       = majority3({rx_s, samp_r});
        stop_eval_s = (state_r == ST_STOP) && tick_s && (scnt_r == SAMPLE_C);
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_s     = ST_START;
                    acc_clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (scnt_r == SAMPLE_C) && maj_s) begin
                    state_s = ST_IDLE;
                end else if (tick_s && (scnt_r == SCNT_LAST)) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (scnt_r == SCNT_LAST) && (bit_idx_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_s = ST_PARITY;
`else
                    state_s = ST_STOP;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s && (scnt_r == SCNT_LAST)) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (stop_eval_s) begin
                    state_s = maj_s ? ST_IDLE : ST_BREAK;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign frame_s   = stop_eval_s && !maj_s;
    assign perr_s    = stop_eval_s && maj_s && par_err_r;
    assign deliver_s = stop_eval_s && maj_s && !par_err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sample counter and the first two majority votes of each bit.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            scnt_r <= 4'd0;
            samp_r <= 2'b00;
        end else begin
            if (acc_clear_s) begin
                scnt_r <= 4'd0;
            end else if (tick_s) begin
                scnt_r <= scnt_r + 4'd1;
            end
            if (tick_s && (scnt_r == SAMPLE_A)) begin
                samp_r[0] <= rx_s;
            end
            if (tick_s && (scnt_r == SAMPLE_B)) begin
                samp_r[1] <= rx_s;
            end
        end
    end

    // LSB-first data shift register and bit index.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
        end else begin
            if (state_r == ST_START) begin
                bit_idx_r <= 3'd0;
            end else if ((state_r == ST_DATA) && tick_s && (scnt_r == SCNT_LAST)) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if ((state_r == ST_DATA) && tick_s && (scnt_r == SAMPLE_C)) begin
                shift_r <= {maj_s, shift_r[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity mismatch, held until the stop bit decides the frame.
    always_ff @(posedge clk) begin
        if (I_rst) begin
            par_err_r <= 1'b0;
        end else if (state_r == ST_START) begin
            par_err_r <= 1'b0;
        end else if ((state_r == ST_PARITY) && tick_s && (scnt_r == SAMPLE_C)) begin
            par_err_r <= maj_s ^ even_parity(shift_r);
        end
    end
`else
    assign par_err_r = 1'b0;
`endif

    // Delivery handshake and one-clk error pulses (frame > parity > overrun).
    always_ff @(posedge clk) begin
        if (I_rst) begin
            O_data       <= 8'd0;
            O_valid      <= 1'b0;
            O_frame_err  <= 1'b0;
            O_parity_err <= 1'b0;
            O_overrun    <= 1'b0;
            O_busy       <= 1'b0;
        end else begin
            O_frame_err  <= frame_s;
            O_parity_err <= perr_s;
            O_overrun    <= deliver_s && O_valid && !I_ready;
            O_busy       <= (state_s != ST_IDLE);
            if (deliver_s && (!O_valid || I_ready)) begin
                O_data  <= shift_r;
                O_valid <= 1'b1;
            end else if (O_valid && I_ready) begin
                O_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame-level model predicts each frame's outcome and time window.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int  CLK_FREQ = 27_000_000;
    localparam int  BAUD     = 115200;
    localparam real BIT_CLK  = 27.0e6 / 115200.0;
`ifdef UART_RX_PARITY_EN
    localparam bit  PAR_EN   = 1'b1;
    localparam real LAT_BITS = 10.5;
`else
    localparam bit  PAR_EN   = 1'b0;
    localparam real LAT_BITS = 9.5;
`endif
    localparam logic [3:0] K_DATA  = 4'b0001;
    localparam logic [3:0] K_FRAME = 4'b0010;
    localparam logic [3:0] K_PAR   = 4'b0100;
    localparam logic [3:0] K_OVR   = 4'b1000;

    logic       clk = 1'b0;
    logic       I_rst, I_rx, I_ready;
    logic [7:0] O_data;
    logic       O_valid, O_frame_err, O_parity_err, O_overrun, O_busy;

    uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .I_rst        (I_rst),
        .I_rx         (I_rx),
        .O_data       (O_data),
        .O_valid      (O_valid),
        .I_ready      (I_ready),
        .O_frame_err  (O_frame_err),
        .O_parity_err (O_parity_err),
        .O_overrun    (O_overrun),
        .O_busy       (O_busy)
    );

    always #18.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        int         t_exp;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       mdl_full = 1'b0;
    logic [7:0] last_data = 8'd0;
    real        resid = 0.0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_level(input logic v, input real clks);
        I_rx = v;
        resid += clks;
        while (resid >= 1.0) begin
            @(negedge clk);
            resid -= 1.0;
        end
    endtask

    // Frame-level model: outcome decided from the frame contents and whether a byte is still held.
    task automatic send_frame(input logic [7:0] d, input real baud, input logic stop_val,
                              input int stop_len, input logic par_flip, input logic track);
        real bclk;
        ev_t e;
        bclk = real'(CLK_FREQ) / baud;
        if (track) begin
            if (!stop_val) begin
                e.kind = K_FRAME;
            end else if (PAR_EN && par_flip) begin
                e.kind = K_PAR;
            end else if (mdl_full) begin
                e.kind = K_OVR;
            end else begin
                e.kind = K_DATA;
                mdl_full = !I_ready;
            end
            e.data  = d;
            e.t_exp = cyc + $rtoi(LAT_BITS * BIT_CLK) + 3;
            exp_q.push_back(e);
        end
        drive_level(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_level(d[i], bclk);
        if (PAR_EN) drive_level((^d) ^ par_flip, bclk);
        drive_level(stop_val, bclk * real'(stop_len));
        I_rx = 1'b1;
    endtask

    task automatic idle_bits(input real n);
        drive_level(1'b1, n * BIT_CLK);
    endtask

    // Compare process: every output event is matched against the next predicted one.
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        logic [3:0] act;
        ev_t        e;
        act = {O_overrun, O_parity_err, O_frame_err, O_valid && (!prev_valid || prev_ready)};
        if (act != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(act), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", 32'(act), 32'(e.kind));
                if (e.kind == K_DATA) begin
                    check("event_data", 32'(O_data), 32'(e.data));
                    last_data = O_data;
                end
                check("event_time", 32'((cyc >= e.t_exp - 8) && (cyc <= e.t_exp + 48)), 32'd1);
            end
        end
        if (prev_err) check("err_pulse_width", 32'({O_overrun, O_parity_err, O_frame_err}), 32'd0);
        prev_valid <= O_valid;
        prev_ready <= I_ready;
        prev_err   <= O_overrun | O_parity_err | O_frame_err;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        I_rst = 1'b1; I_rx = 1'b1; I_ready = 1'b1;
        repeat (5) @(negedge clk);
        I_rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(O_valid), 32'd0);
        check("rst_busy", 32'(O_busy), 32'd0);
        check("rst_data", 32'(O_data), 32'd0);
        check("rst_errs", 32'({O_frame_err, O_parity_err, O_overrun}), 32'd0);
        idle_bits(1.0);

        // Single byte
        send_frame(8'h55, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("single_data", 32'(last_data), 32'h55);
        check("single_busy_low", 32'(O_busy), 32'd0);
        check("single_valid_consumed", 32'(O_valid), 32'd0);

        // Start glitch shorter than half a bit
        drive_level(1'b0, 10.0);
        check("glitch_busy_high", 32'(O_busy), 32'd1);
        drive_level(1'b0, 40.0);
        drive_level(1'b1, 300.0);
        check("glitch_busy_low", 32'(O_busy), 32'd0);
        send_frame(8'hA3, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("after_glitch_data", 32'(last_data), 32'hA3);

        // Framing error with stop held low for two bits
        send_frame(8'h0F, real'(BAUD), 1'b0, 2, 1'b0, 1'b1);
        idle_bits(1.0);
        check("frame_busy_low", 32'(O_busy), 32'd0);
        send_frame(8'h7E, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("after_frame_data", 32'(last_data), 32'h7E);

        // Overrun: two back-to-back frames with the consumer stalled
        I_ready = 1'b0;
        send_frame(8'hA5, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        send_frame(8'h3C, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("overrun_valid_held", 32'(O_valid), 32'd1);
        check("overrun_data_kept", 32'(O_data), 32'hA5);
        I_ready = 1'b1;
        mdl_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("overrun_valid_cleared", 32'(O_valid), 32'd0);

        // Baud skew +/-3%
        send_frame(8'h00, real'(BAUD) * 1.03, 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("skew_fast_data", 32'(last_data), 32'h00);
        send_frame(8'hFF, real'(BAUD) * 0.97, 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("skew_slow_data", 32'(last_data), 32'hFF);

        // Reset in the middle of the data bits
        fork
            send_frame(8'hFF, real'(BAUD), 1'b1, 1, 1'b0, 1'b0);
            begin
                repeat (4 * 235) @(negedge clk);
                check("pre_reset_busy", 32'(O_busy), 32'd1);
                I_rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("reset_busy", 32'(O_busy), 32'd0);
                check("reset_valid", 32'(O_valid), 32'd0);
                I_rst = 1'b0;
            end
        join
        idle_bits(2.0);
        check("post_reset_busy", 32'(O_busy), 32'd0);
        send_frame(8'h3C, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("post_reset_data", 32'(last_data), 32'h3C);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, real'(BAUD), 1'b1, 1, 1'b1, 1'b1);
        idle_bits(2.0);
        check("parity_bad_no_valid", 32'(O_valid), 32'd0);
        send_frame(8'h01, real'(BAUD), 1'b1, 1, 1'b0, 1'b1);
        idle_bits(2.0);
        check("parity_good_data", 32'(last_data), 32'h01);
`endif

        check("events_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
